// File: rtl/logger_event_if.sv
// Record stream from the event writer to the logger.
// The writer drives valid/data/ts/gap and the logger drives ready.
interface logger_event_if #(
    parameter int DATA_W = 32,
    parameter int TS_W   = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TS_W-1:0]   out_ts;
    logic              out_gap;

    modport master (
        output out_valid,
        output out_data,
        output out_ts,
        output out_gap,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_ts,
        input  out_gap,
        output out_ready
    );
endinterface

// File: rtl/logger_event_writer.sv
// Change-detecting event writer for the logger.
// Samples a watched bus every clk, turns each value change into a
// timestamped record, buffers records in a small FIFO and offers them on
// a valid/ready stream. Records that find the FIFO full are dropped,
// counted, and flagged on the next record that gets through.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | enable low; counter holds, nothing is captured
// FIRST | first enabled cycle; current sample is recorded unconditionally
// RUN   | later enabled cycles; a record is made only when the bus changed
module logger_event_writer #(
    parameter int DATA_W = 32,
    parameter int TS_W   = 32,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [DATA_W-1:0]        sample_data,
    logger_event_if.master           evt,
    output logic [15:0]              lost_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [AW:0]     LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]     LVL_FULL = (AW + 1)'(DEPTH);
    localparam logic [TS_W-1:0] TS_ONE   = TS_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [TS_W-1:0]   ts_q;
    logic [DATA_W-1:0] prev_q;
    logic              gap_pending_q;
    logic [15:0]       lost_q;

    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       level_q;
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [TS_W-1:0]   mem_ts   [DEPTH];
    logic              mem_gap  [DEPTH];

    logic push_req;
    logic clear_ts;
    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic accept;
    logic drop;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, push request and counter clear for the current sample.
    always_comb begin
        state_d  = state_q;
        push_req = 1'b0;
        clear_ts = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d  = FIRST;
                    clear_ts = 1'b1;
                end
            end
            FIRST: begin
                if (enable) begin
                    state_d  = RUN;
                    push_req = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (enable) begin
                    push_req = (sample_data != prev_q);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO status and the accept/drop decision. A pop in the same cycle
    // frees the slot, so a full FIFO still accepts a push alongside a pop.
    always_comb begin
        fifo_full  = (level_q == LVL_FULL);
        fifo_empty = (level_q == '0);
        pop        = !fifo_empty && evt.out_ready;
        accept     = push_req && (!fifo_full || pop);
        drop       = push_req && fifo_full && !pop;
    end

    // Timestamp counter: restarts on enable rising, free-runs (wrapping)
    // while capturing, holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else if (clear_ts) begin
            ts_q <= '0;
        end else if (state_q != IDLE) begin
            ts_q <= ts_q + TS_ONE;
        end
    end

    // Previous-sample register for change detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else if (enable) begin
            prev_q <= sample_data;
        end
    end

    // Drop bookkeeping: saturating loss count and a sticky gap marker that
    // the next stored record picks up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lost_q        <= '0;
            gap_pending_q <= 1'b0;
        end else if (drop) begin
            if (lost_q != 16'hFFFF) begin
                lost_q <= lost_q + 16'd1;
            end
            gap_pending_q <= 1'b1;
        end else if (accept) begin
            gap_pending_q <= 1'b0;
        end
    end

    // Record storage; cleared on reset so the stream reads zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_ts[i]   <= '0;
                mem_gap[i]  <= 1'b0;
            end
        end else if (accept) begin
            mem_data[wr_ptr_q] <= sample_data;
            mem_ts[wr_ptr_q]   <= ts_q;
            mem_gap[wr_ptr_q]  <= gap_pending_q;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({accept, pop})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    assign evt.out_valid = !fifo_empty;
    assign evt.out_data  = mem_data[rd_ptr_q];
    assign evt.out_ts    = mem_ts[rd_ptr_q];
    assign evt.out_gap   = mem_gap[rd_ptr_q];
    assign lost_cnt      = lost_q;
    assign level         = level_q;

endmodule

// File: tb/tb_logger_event_writer.sv
// Bench for logger_event_writer: directed scenarios plus a random run,
// every cycle compared against a queue-based model of the record stream.
// A narrow timestamp is used so counter wrap-around shows up in the run.
module tb_logger_event_writer;

    localparam int DATA_W = 32;
    localparam int TS_W   = 8;
    localparam int DEPTH  = 16;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   enable;
    logic [DATA_W-1:0]      sample_data;
    logic [15:0]            lost_cnt;
    logic [$clog2(DEPTH):0] level;

    logger_event_if #(.DATA_W(DATA_W), .TS_W(TS_W)) evt_if ();

    logger_event_writer #(.DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .sample_data (sample_data),
        .evt         (evt_if),
        .lost_cnt    (lost_cnt),
        .level       (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [TS_W-1:0]   ts;
        logic              gap;
    } rec_t;

    int vectors     = 0;
    int miscompares = 0;

    // Model: FIFO contents as a queue, plus capture status.
    rec_t              mq[$];
    int                m_phase;   // 0 idle, 1 first enabled cycle, 2 running
    logic [TS_W-1:0]   m_ts;
    logic [DATA_W-1:0] m_prev;
    logic              m_gap;
    int                m_lost;

    // Observed-stream bookkeeping for the literal checks.
    int                xfers;
    int                gap_idx;
    logic [DATA_W-1:0] gap_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_phase = 0;
        m_ts    = '0;
        m_prev  = '0;
        m_gap   = 1'b0;
        m_lost  = 0;
    endtask

    task automatic check_all();
        chk("out_valid", evt_if.out_valid, (mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_data", evt_if.out_data, mq[0].data);
            chk("out_ts",   evt_if.out_ts,   mq[0].ts);
            chk("out_gap",  evt_if.out_gap,  mq[0].gap);
        end
        chk("level",    level,    mq.size());
        chk("lost_cnt", lost_cnt, m_lost);
    endtask

    // Advance the model by one clock using the inputs currently applied,
    // clock the DUT, then compare at the following falling edge.
    task automatic cycle();
        int   sz;
        bit   pop;
        bit   want;
        rec_t r;
        if (evt_if.out_valid && evt_if.out_ready) begin
            if (evt_if.out_gap && gap_idx < 0) begin
                gap_idx  = xfers;
                gap_data = evt_if.out_data;
            end
            xfers++;
        end
        sz   = mq.size();
        pop  = (sz != 0) && evt_if.out_ready;
        want = enable && (m_phase != 0) && (m_phase == 1 || sample_data != m_prev);
        r    = '{data: sample_data, ts: m_ts, gap: m_gap};
        if (pop) void'(mq.pop_front());
        if (want) begin
            if (sz < DEPTH || pop) begin
                mq.push_back(r);
                m_gap = 1'b0;
            end else begin
                if (m_lost < 65535) m_lost++;
                m_gap = 1'b1;
            end
        end
        if (m_phase == 0 && enable) m_ts = '0;
        else if (m_phase != 0)      m_ts = m_ts + 1'b1;
        if (enable) m_prev = sample_data;
        m_phase = !enable ? 0 : (m_phase == 0 ? 1 : 2);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int rdy_pct;

        rst_n            = 1'b0;
        enable           = 1'b0;
        sample_data      = '0;
        evt_if.out_ready = 1'b0;
        model_reset();
        xfers   = 0;
        gap_idx = -1;
        repeat (2) @(negedge clk);

        chk("rst_valid", evt_if.out_valid, 0);
        chk("rst_data",  evt_if.out_data,  0);
        chk("rst_ts",    evt_if.out_ts,    0);
        chk("rst_gap",   evt_if.out_gap,   0);
        chk("rst_level", level,            0);
        chk("rst_lost",  lost_cnt,         0);
        rst_n = 1'b1;

        // Constant bus: exactly one record (the FIRST-cycle capture).
        enable           = 1'b1;
        sample_data      = 32'hA5;
        evt_if.out_ready = 1'b1;
        xfers            = 0;
        cycle();
        cycle();
        chk("s1_valid", evt_if.out_valid, 1);
        chk("s1_data",  evt_if.out_data,  32'hA5);
        chk("s1_ts",    evt_if.out_ts,    0);
        chk("s1_gap",   evt_if.out_gap,   0);
        repeat (8) cycle();
        chk("s1_count", xfers, 1);

        // Re-enable, then changes at timestamps 5, 6, 7.
        enable = 1'b0;
        cycle();
        enable = 1'b1;
        cycle();
        cycle();
        repeat (4) cycle();
        for (int i = 1; i <= 3; i++) begin
            sample_data = DATA_W'(i);
            cycle();
            chk("s2_valid", evt_if.out_valid, 1);
            chk("s2_data",  evt_if.out_data,  i);
            chk("s2_ts",    evt_if.out_ts,    4 + i);
        end

        // Overflow: 20 pushes into a 16-deep FIFO with the consumer stalled.
        enable = 1'b0;
        cycle();
        evt_if.out_ready = 1'b0;
        enable           = 1'b1;
        cycle();
        for (int i = 0; i < 20; i++) begin
            sample_data = DATA_W'(100 + i);
            cycle();
        end
        chk("s3_level", level,    16);
        chk("s3_lost",  lost_cnt, 4);

        // Push and pop together while full, then drain.
        evt_if.out_ready = 1'b1;
        sample_data      = DATA_W'(200);
        xfers            = 0;
        gap_idx          = -1;
        cycle();
        chk("s3_pp_level", level,    16);
        chk("s3_pp_lost",  lost_cnt, 4);
        repeat (20) cycle();
        chk("s3_drained",  xfers,    17);
        chk("s3_gap_idx",  gap_idx,  16);
        chk("s3_gap_data", gap_data, 200);

        // Stall with a record waiting; model checks stability each cycle.
        evt_if.out_ready = 1'b0;
        sample_data      = DATA_W'(300);
        cycle();
        repeat (5) cycle();
        chk("s4_valid", evt_if.out_valid, 1);
        chk("s4_data",  evt_if.out_data,  300);

        // Fill to 7 and reset asynchronously between clock edges.
        for (int i = 1; i <= 6; i++) begin
            sample_data = DATA_W'(300 + i);
            cycle();
        end
        chk("s5_level_pre", level, 7);
        rst_n = 1'b0;
        #1;
        chk("s5_rst_valid", evt_if.out_valid, 0);
        chk("s5_rst_level", level,            0);
        chk("s5_rst_lost",  lost_cnt,         0);
        model_reset();
        #2;
        rst_n            = 1'b1;
        evt_if.out_ready = 1'b1;
        sample_data      = DATA_W'(400);
        cycle();
        cycle();
        chk("s5_valid", evt_if.out_valid, 1);
        chk("s5_data",  evt_if.out_data,  400);
        chk("s5_ts",    evt_if.out_ts,    0);

        // Random traffic: long enabled runs (timestamp wraps), varying
        // consumer throughput so the FIFO fills and drains.
        rdy_pct = 50;
        for (int n = 0; n < 1500; n++) begin
            if (n % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0:       rdy_pct = 15;
                    1:       rdy_pct = 55;
                    default: rdy_pct = 95;
                endcase
            end
            enable = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 2) != 0) sample_data = DATA_W'($urandom_range(0, 3));
            evt_if.out_ready = ($urandom_range(0, 99) < rdy_pct);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
